cart_sdram_arbiter: RTL
=======================

// Module: cart_sdram_arbiter
// PURPOSE
//  Shares the single cartridge SDRAM port among three requesters: CPU cart reads (mapper mbc_addr),
//  ROM loader writes and savestate byte reads/writes. Sits between the active mapper's
//  address output and the SDRAM controller. Sequences one access at a time with a
//  req/ack handshake, a starvation guard for background traffic and an ack timeout.
// PARAMETERS
//  STARVE_MAX  4    consecutive CPU grants allowed while background requests wait (1..15)
//  TIMEOUT     255  max cycles in WAIT without sd_ack before the access is aborted (1..255)
// PORTS
//  clk_sys      in   1   system clock; all logic on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  cpu_req      in   1   1-cycle pulse: read request at cpu_addr
//  cpu_addr     in   23  byte address (mapper mbc_addr)
//  cpu_rdata    out  8   read data, valid while cpu_valid=1, held after
//  cpu_valid    out  1   1-cycle pulse: cpu_rdata updated
//  ld_req       in   1   level: loader write pending, held until ld_ack
//  ld_addr      in   23  loader write address
//  ld_wdata     in   8   loader write data
//  ld_ack       out  1   1-cycle pulse: loader write done
//  ss_req       in   1   level: savestate access pending, held until ss_ack
//  ss_we        in   1   1=write, 0=read
//  ss_addr      in   23  savestate address
//  ss_wdata     in   8   savestate write data
//  ss_rdata     out  8   savestate read data, valid with ss_ack, held after
//  ss_ack       out  1   1-cycle pulse: savestate access done
//  sd_req       out  1   1-cycle pulse to SDRAM controller: start access
//  sd_we        out  1   access is a write; stable ISSUE..DONE
//  sd_addr      out  23  access address; stable ISSUE..DONE
//  sd_wdata     out  8   write data; stable ISSUE..DONE
//  sd_ack       in   1   1-cycle pulse: access complete; sampled only in WAIT
//  sd_rdata     in   8   read data, valid with sd_ack
//  timeout_err  out  1   sticky: an access timed out; cleared only by reset
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; cpu_pend=0; starve_cnt=0; rr=0 (loader next);
//   sd_req/sd_we/cpu_valid/ld_ack/ss_ack/timeout_err=0; sd_addr=0; sd_wdata=0;
//   cpu_rdata=8'hFF; ss_rdata=8'h00. Reset mid-access abandons it; no ack/valid is issued.
//  cpu_req latches cpu_addr into cpu_pend in any state; a new pulse while pending
//   overwrites the address (latest wins, one read served). CPU pending = cpu_pend | cpu_req.
//  FSM IDLE->ISSUE->WAIT->DONE->IDLE:
//   IDLE : pick a grant if any request; else stay. Grant registers sd_addr/we/wdata.
//   ISSUE: exactly 1 cycle, sd_req=1. sd_ack here is ignored (controller acks >=1 cycle later).
//   WAIT : sd_ack -> capture sd_rdata, go DONE. wait_cnt==TIMEOUT-1 without ack -> DONE,
//          read data forced 8'hFF, timeout_err<=1.
//   DONE : exactly 1 cycle, pulse owner's cpu_valid/ld_ack/ss_ack with data; clear cpu_pend
//          if CPU owned (unless a cpu_req arrives in that same cycle, which re-arms it).
//  Requests are evaluated only in IDLE, so level requesters have the DONE cycle to drop/update req.
//  Grant priority in IDLE:
//   - CPU pending and (starve_cnt<STARVE_MAX or no ld/ss request) -> CPU.
//   - else loader vs savestate round-robin: rr selects first choice if requesting,
//     else the other; rr toggles to point away from the winner.
//   starve_cnt: +1 on a CPU grant while ld_req|ss_req=1 (saturating); 0 on any background
//   grant or on a CPU grant with no background request pending.
//  Latency (sd_ack 1 cycle after sd_req): cpu_req in IDLE cycle 0 -> sd_req cycle 1 ->
//   sd_ack cycle 2 -> cpu_valid cycle 3. Back-to-back min period 4 cycles.
//  wait_cnt: 8 bit, cleared entering WAIT; no wrap (TIMEOUT<=255).
// TESTING
//  Single CPU read, sd_ack 1 cycle after sd_req, sd_rdata=8'h3C -> cpu_valid at cycle 3, cpu_rdata=8'h3C.
//  ld_req+ss_req held, no CPU -> grants alternate ld,ss,ld,ss; each ack exactly once per grant.
//  cpu_req every 4 cycles + ld_req held, STARVE_MAX=4 -> 4 CPU grants, 1 loader grant, repeat.
//  Two cpu_req pulses (addr 0x100, 0x200) during a loader access -> one CPU read at 0x200.
//  sd_ack withheld, TIMEOUT=8 -> ss_ack 8 cycles into WAIT, ss_rdata=8'hFF, timeout_err=1 until reset.
//  reset_n low during WAIT -> all outputs at reset values immediately; no ack after release.

Source files
------------

// File: rtl/cart_sdram_arbiter.sv
// cart_sdram_arbiter
//   Shares the cartridge SDRAM port between CPU cart reads, ROM loader writes
//   and savestate byte accesses. One access is in flight at a time and moves
//   through IDLE -> ISSUE -> WAIT -> DONE. A starvation guard limits how many
//   CPU grants in a row can pass waiting background traffic. A WAIT timeout
//   aborts an access that never gets sd_ack.
//
// Ports
//   clk_sys, reset_n                  clock, asynchronous active-low reset
//   cpu_req/cpu_addr                  1-cycle read request pulse + byte address
//   cpu_rdata/cpu_valid               read data (held), 1-cycle update pulse
//   ld_req/ld_addr/ld_wdata/ld_ack    loader write, level req until ack pulse
//   ss_req/ss_we/ss_addr/ss_wdata     savestate access, level req until ack
//   ss_rdata/ss_ack                   savestate read data (held), ack pulse
//   sd_req/sd_we/sd_addr/sd_wdata     access to the SDRAM controller
//   sd_ack/sd_rdata                   completion pulse + read data from it
//   timeout_err                       sticky flag: some access timed out
module cart_sdram_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [22:0] cpu_addr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_valid,
  input  logic        ld_req,
  input  logic [22:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  output logic        ld_ack,
  input  logic        ss_req,
  input  logic        ss_we,
  input  logic [22:0] ss_addr,
  input  logic [7:0]  ss_wdata,
  output logic [7:0]  ss_rdata,
  output logic        ss_ack,
  output logic        sd_req,
  output logic        sd_we,
  output logic [22:0] sd_addr,
  output logic [7:0]  sd_wdata,
  input  logic        sd_ack,
  input  logic [7:0]  sd_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_LD, OWN_SS} owner_t;

  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        cpu_pend_q, cpu_pend_d;
  logic [22:0] cpu_paddr_q, cpu_paddr_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rr_q, rr_d;            // 0: loader is first choice
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        sd_req_q, sd_req_d;
  logic        sd_we_q, sd_we_d;
  logic [22:0] sd_addr_q, sd_addr_d;
  logic [7:0]  sd_wdata_q, sd_wdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_valid_q, cpu_valid_d;
  logic        ld_ack_q, ld_ack_d;
  logic        ss_ack_q, ss_ack_d;
  logic [7:0]  ss_rdata_q, ss_rdata_d;
  logic        timeout_err_q, timeout_err_d;

  logic        cpu_any;
  logic        bg_any;
  logic        pick_ld;
  logic [7:0]  rdata_fin;

  // A request pulse in the grant cycle itself counts as pending.
  assign cpu_any   = cpu_pend_q | cpu_req;
  assign bg_any    = ld_req | ss_req;
  assign pick_ld   = ld_req & (~rr_q | ~ss_req);
  assign rdata_fin = sd_ack ? sd_rdata : 8'hFF;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cpu_pend_d    = cpu_pend_q;
    cpu_paddr_d   = cpu_paddr_q;
    starve_cnt_d  = starve_cnt_q;
    rr_d          = rr_q;
    wait_cnt_d    = wait_cnt_q;
    sd_req_d      = 1'b0;
    sd_we_d       = sd_we_q;
    sd_addr_d     = sd_addr_q;
    sd_wdata_d    = sd_wdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_valid_d   = 1'b0;
    ld_ack_d      = 1'b0;
    ss_ack_d      = 1'b0;
    ss_rdata_d    = ss_rdata_q;
    timeout_err_d = timeout_err_q;

    // Latest CPU request wins; only one read is served for it.
    if (cpu_req) begin
      cpu_pend_d  = 1'b1;
      cpu_paddr_d = cpu_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_any && ((starve_cnt_q < STARVE_LIM) || !bg_any)) begin
          owner_d    = OWN_CPU;
          sd_we_d    = 1'b0;
          sd_addr_d  = cpu_req ? cpu_addr : cpu_paddr_q;
          sd_wdata_d = 8'h00;
          if (!bg_any)
            starve_cnt_d = 4'd0;
          else if (starve_cnt_q != 4'hF)
            starve_cnt_d = starve_cnt_q + 4'd1;
          sd_req_d = 1'b1;
          state_d  = ST_ISSUE;
        end else if (bg_any) begin
          starve_cnt_d = 4'd0;
          if (pick_ld) begin
            owner_d    = OWN_LD;
            sd_we_d    = 1'b1;
            sd_addr_d  = ld_addr;
            sd_wdata_d = ld_wdata;
            rr_d       = 1'b1;
          end else begin
            owner_d    = OWN_SS;
            sd_we_d    = ss_we;
            sd_addr_d  = ss_addr;
            sd_wdata_d = ss_wdata;
            rr_d       = 1'b0;
          end
          sd_req_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // sd_ack is not looked at here; the controller answers later.
        wait_cnt_d = 8'd0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (sd_ack || (wait_cnt_q == WAIT_LAST)) begin
          if (!sd_ack)
            timeout_err_d = 1'b1;
          case (owner_q)
            OWN_CPU: begin
              cpu_valid_d = 1'b1;
              cpu_rdata_d = rdata_fin;
            end
            OWN_LD: ld_ack_d = 1'b1;
            default: begin
              ss_ack_d = 1'b1;
              if (!sd_we_q)
                ss_rdata_d = rdata_fin;
            end
          endcase
          state_d = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // A cpu_req landing in this very cycle keeps the CPU pending.
        if ((owner_q == OWN_CPU) && !cpu_req)
          cpu_pend_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_CPU;
      cpu_pend_q    <= 1'b0;
      cpu_paddr_q   <= '0;
      starve_cnt_q  <= 4'd0;
      rr_q          <= 1'b0;
      wait_cnt_q    <= 8'd0;
      sd_req_q      <= 1'b0;
      sd_we_q       <= 1'b0;
      sd_addr_q     <= '0;
      sd_wdata_q    <= 8'h00;
      cpu_rdata_q   <= 8'hFF;
      cpu_valid_q   <= 1'b0;
      ld_ack_q      <= 1'b0;
      ss_ack_q      <= 1'b0;
      ss_rdata_q    <= 8'h00;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cpu_pend_q    <= cpu_pend_d;
      cpu_paddr_q   <= cpu_paddr_d;
      starve_cnt_q  <= starve_cnt_d;
      rr_q          <= rr_d;
      wait_cnt_q    <= wait_cnt_d;
      sd_req_q      <= sd_req_d;
      sd_we_q       <= sd_we_d;
      sd_addr_q     <= sd_addr_d;
      sd_wdata_q    <= sd_wdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_valid_q   <= cpu_valid_d;
      ld_ack_q      <= ld_ack_d;
      ss_ack_q      <= ss_ack_d;
      ss_rdata_q    <= ss_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign sd_req      = sd_req_q;
  assign sd_we       = sd_we_q;
  assign sd_addr     = sd_addr_q;
  assign sd_wdata    = sd_wdata_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_valid   = cpu_valid_q;
  assign ld_ack      = ld_ack_q;
  assign ss_ack      = ss_ack_q;
  assign ss_rdata    = ss_rdata_q;
  assign timeout_err = timeout_err_q;

endmodule
